mem_req_ctrl: RTL and testbench

//  Cache-side initiator for the main-memory read/write channels.

---
 rtl/mem_req_ctrl_if.sv | 44 ++++
 rtl/mem_req_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_if.sv
// Bundle of the cache-side refill/store ports and the main-memory read/write
// channels seen by mem_req_ctrl; master is the controller, slave its environment.
interface mem_req_ctrl_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int CACHE_LINE_WIDTH = 256
);
    logic                        i_refill_req;
    logic [ADDR_WIDTH-1:0]       i_refill_addr;
    logic                        o_refill_busy;
    logic                        o_refill_done;
    logic [CACHE_LINE_WIDTH-1:0] o_refill_line;
    logic                        i_wr_valid;
    logic [ADDR_WIDTH-1:0]       i_wr_addr;
    logic [DATA_WIDTH-1:0]       i_wr_data;
    logic [3:0]                  i_wr_be;
    logic                        o_wr_ready;
    logic                        o_wb_empty;
    logic [ADDR_WIDTH-1:0]       o_mem_read_address;
    logic                        o_mem_read_req;
    logic                        i_mem_read_done;
    logic [CACHE_LINE_WIDTH-1:0] i_cache_line;
    logic                        o_mem_write_valid;
    logic [ADDR_WIDTH-1:0]       o_mem_write_address;
    logic [DATA_WIDTH-1:0]       o_mem_write_data;
    logic [7:0]                  o_write_strobe;
    logic                        i_mem_write_done;

    modport master (
        input  i_refill_req, i_refill_addr, i_wr_valid, i_wr_addr, i_wr_data, i_wr_be,
               i_mem_read_done, i_cache_line, i_mem_write_done,
        output o_refill_busy, o_refill_done, o_refill_line, o_wr_ready, o_wb_empty,
               o_mem_read_address, o_mem_read_req, o_mem_write_valid,
               o_mem_write_address, o_mem_write_data, o_write_strobe
    );

    modport slave (
        output i_refill_req, i_refill_addr, i_wr_valid, i_wr_addr, i_wr_data, i_wr_be,
               i_mem_read_done, i_cache_line, i_mem_write_done,
        input  o_refill_busy, o_refill_done, o_refill_line, o_wr_ready, o_wb_empty,
               o_mem_read_address, o_mem_read_req, o_mem_write_valid,
               o_mem_write_address, o_mem_write_data, o_write_strobe
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Cache-side memory initiator: drains a write-through store buffer and issues
// line refills, never letting a refill overtake a store buffered before it.
module mem_req_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int WB_DEPTH         = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mem_req_ctrl_if.master bus
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(WB_DEPTH);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_ISSUE = 3'd1;
    localparam logic [2:0] ST_WR_WAIT  = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_WAIT  = 3'd4;

    logic [ADDR_WIDTH-1:0]       wb_addr_r [WB_DEPTH];
    logic [DATA_WIDTH-1:0]       wb_data_r [WB_DEPTH];
    logic [3:0]                  wb_be_r   [WB_DEPTH];
    logic [PW-1:0]               wr_ptr_r;
    logic [PW-1:0]               rd_ptr_r;
    logic [CW-1:0]               count_r;
    logic [2:0]                  state_r;
    logic                        busy_r;
    logic [ADDR_WIDTH-1:0]       raddr_r;
    logic                        refill_done_r;
    logic [CACHE_LINE_WIDTH-1:0] refill_line_r;
    logic                        wr_ready_r;
    logic                        wb_empty_r;
    logic                        mem_read_req_r;
    logic [ADDR_WIDTH-1:0]       mem_read_address_r;
    logic                        mem_write_valid_r;
    logic [ADDR_WIDTH-1:0]       mem_write_address_r;
    logic [DATA_WIDTH-1:0]       mem_write_data_r;
    logic [7:0]                  write_strobe_r;

    logic                        push_s;
    logic                        pop_s;
    logic                        accept_s;
    logic                        read_ret_s;
    logic [CW-1:0]               count_next_s;
    logic                        busy_next_s;
    logic                        full_next_s;
    logic [2:0]                  state_next_s;

    assign push_s      = bus.i_wr_valid & wr_ready_r;
    assign pop_s       = (state_r == ST_WR_WAIT) & bus.i_mem_write_done;
    assign accept_s    = bus.i_refill_req & ~busy_r;
    assign read_ret_s  = (state_r == ST_RD_WAIT) & bus.i_mem_read_done;
    assign full_next_s = (count_next_s == CNT_FULL);

    assign bus.o_refill_busy       = busy_r;
    assign bus.o_refill_done       = refill_done_r;
    assign bus.o_refill_line       = refill_line_r;
    assign bus.o_wr_ready          = wr_ready_r;
    assign bus.o_wb_empty          = wb_empty_r;
    assign bus.o_mem_read_req      = mem_read_req_r;
    assign bus.o_mem_read_address  = mem_read_address_r;
    assign bus.o_mem_write_valid   = mem_write_valid_r;
    assign bus.o_mem_write_address = mem_write_address_r;
    assign bus.o_mem_write_data    = mem_write_data_r;
    assign bus.o_write_strobe      = write_strobe_r;

    // Buffer occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Refill-busy flag: set on accept, cleared when the line comes back.
    always_comb begin
        busy_next_s = busy_r;
        if (accept_s) begin
            busy_next_s = 1'b1;
        end else if (read_ret_s) begin
            busy_next_s = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
    end

    // Channel sequencer; a refill accepted with a same-cycle store push waits
    // a cycle so the store is seen in the buffer first.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_ZERO) begin
                    state_next_s = ST_WR_ISSUE;
                end else if ((busy_r | accept_s) & ~push_s) begin
                    state_next_s = ST_RD_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WR_ISSUE: state_next_s = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (pop_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WR_WAIT;
                end
            end
            ST_RD_ISSUE: state_next_s = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (read_ret_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RD_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Store buffer payload; only the pointers need a reset.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            wb_addr_r[wr_ptr_r] <= bus.i_wr_addr;
            wb_data_r[wr_ptr_r] <= bus.i_wr_data;
            wb_be_r[wr_ptr_r]   <= bus.i_wr_be;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r            <= {PW{1'b0}};
            rd_ptr_r            <= {PW{1'b0}};
            count_r             <= CNT_ZERO;
            state_r             <= ST_IDLE;
            busy_r              <= 1'b0;
            raddr_r             <= {ADDR_WIDTH{1'b0}};
            refill_done_r       <= 1'b0;
            refill_line_r       <= {CACHE_LINE_WIDTH{1'b0}};
            wr_ready_r          <= 1'b1;
            wb_empty_r          <= 1'b1;
            mem_read_req_r      <= 1'b0;
            mem_read_address_r  <= {ADDR_WIDTH{1'b0}};
            mem_write_valid_r   <= 1'b0;
            mem_write_address_r <= {ADDR_WIDTH{1'b0}};
            mem_write_data_r    <= {DATA_WIDTH{1'b0}};
            write_strobe_r      <= 8'h00;
        end else begin
            state_r       <= state_next_s;
            count_r       <= count_next_s;
            busy_r        <= busy_next_s;
            wr_ready_r    <= ~full_next_s & ~busy_next_s;
            wb_empty_r    <= (count_next_s == CNT_ZERO);
            refill_done_r <= read_ret_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (accept_s) begin
                raddr_r <= bus.i_refill_addr;
            end
            if (read_ret_s) begin
                refill_line_r <= bus.i_cache_line;
            end
            mem_write_valid_r <= (state_next_s == ST_WR_ISSUE);
            if (state_next_s == ST_WR_ISSUE) begin
                mem_write_address_r <= wb_addr_r[rd_ptr_r];
                mem_write_data_r    <= wb_data_r[rd_ptr_r];
                write_strobe_r      <= {4'b0000, wb_be_r[rd_ptr_r]};
            end
            // The address may be accepted on the same edge the read is issued.
            mem_read_req_r <= (state_next_s == ST_RD_ISSUE);
            if (state_next_s == ST_RD_ISSUE) begin
                mem_read_address_r <= accept_s ? bus.i_refill_addr : raddr_r;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed and randomized bench for mem_req_ctrl against a transaction-level
// model: FIFO of expected stores, refill bookkeeping and a latency-random memory.
module tb_mem_req_ctrl;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int CLW = 256;
    localparam int WBD = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    be;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_LINE_WIDTH(CLW)) bus ();

    mem_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_LINE_WIDTH(CLW), .WB_DEPTH(WBD)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;

    wr_t            expwq[$];
    int             m_count;
    bit             m_busy;
    logic [AW-1:0]  m_raddr;
    bit             w_if, r_if;
    int             w_cnt, r_cnt;
    int             wlat_fix, rlat_fix;
    logic [AW-1:0]  h_addr;
    logic [DW-1:0]  h_data;
    logic [7:0]     h_strb;
    bit             exp_ready, exp_empty, exp_rdone;
    logic [CLW-1:0] exp_line;
    bit             chk_en;
    bit             extra_wd, extra_rd;
    int             t_wv = -1, t_rr = -1, t_rdone = -1, t_er = -1;
    int             n_wv = 0, n_rdone = 0;
    bit             prev_empty;
    logic [7:0]     last_strb;

    task automatic check(input string tag, input logic [CLW-1:0] obs, input logic [CLW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CLW-1:0] rand_line();
        logic [CLW-1:0] l;
        for (int i = 0; i < CLW / 32; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    task automatic set_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = a;
        bus.i_wr_data  = d;
        bus.i_wr_be    = be;
    endtask

    task automatic check_reset_outputs();
        check("rst_read_req",   CLW'(bus.o_mem_read_req),      CLW'(0));
        check("rst_write_val",  CLW'(bus.o_mem_write_valid),   CLW'(0));
        check("rst_read_addr",  CLW'(bus.o_mem_read_address),  CLW'(0));
        check("rst_write_addr", CLW'(bus.o_mem_write_address), CLW'(0));
        check("rst_write_data", CLW'(bus.o_mem_write_data),    CLW'(0));
        check("rst_strobe",     CLW'(bus.o_write_strobe),      CLW'(0));
        check("rst_refill_done", CLW'(bus.o_refill_done),      CLW'(0));
        check("rst_refill_line", bus.o_refill_line,            CLW'(0));
        check("rst_busy",       CLW'(bus.o_refill_busy),       CLW'(0));
        check("rst_wr_ready",   CLW'(bus.o_wr_ready),          CLW'(1));
        check("rst_wb_empty",   CLW'(bus.o_wb_empty),          CLW'(1));
    endtask

    // One clock cycle: check outputs, play memory, update the model, advance.
    task automatic cyc();
        wr_t f;
        bit  wv_now, rr_now, outst, push, acc, wpop, rret;
        outst  = w_if || r_if;
        wv_now = (bus.o_mem_write_valid === 1'b1);
        rr_now = (bus.o_mem_read_req === 1'b1);
        if (chk_en) begin
            check("wr_ready",    CLW'(bus.o_wr_ready),    CLW'(exp_ready));
            check("wb_empty",    CLW'(bus.o_wb_empty),    CLW'(exp_empty));
            check("refill_done", CLW'(bus.o_refill_done), CLW'(exp_rdone));
            check("refill_busy", CLW'(bus.o_refill_busy), CLW'(m_busy));
            check("refill_line", bus.o_refill_line,       exp_line);
            check("rd_wr_excl",  CLW'(bus.o_mem_read_req & bus.o_mem_write_valid), CLW'(0));
            if (bus.o_refill_done === 1'b1) begin
                t_rdone = cyc_n;
                n_rdone++;
            end
            if (bus.o_wb_empty === 1'b1 && !prev_empty) t_er = cyc_n;
            prev_empty = (bus.o_wb_empty === 1'b1);
            if (wv_now) begin
                check("w_outstanding", CLW'(outst), CLW'(0));
                check("w_expected", CLW'(expwq.size() != 0), CLW'(1));
                if (expwq.size() != 0) begin
                    f = expwq.pop_front();
                    check("w_addr",   CLW'(bus.o_mem_write_address), CLW'(f.a));
                    check("w_data",   CLW'(bus.o_mem_write_data),    CLW'(f.d));
                    check("w_strobe", CLW'(bus.o_write_strobe),      CLW'({4'b0000, f.be}));
                end
                w_if      = 1'b1;
                w_cnt     = (wlat_fix != 0) ? wlat_fix : int'($urandom_range(3, 1));
                h_addr    = bus.o_mem_write_address;
                h_data    = bus.o_mem_write_data;
                h_strb    = bus.o_write_strobe;
                last_strb = bus.o_write_strobe;
                t_wv      = cyc_n;
                n_wv++;
            end else if (w_if) begin
                check("w_hold_addr", CLW'(bus.o_mem_write_address), CLW'(h_addr));
                check("w_hold_data", CLW'(bus.o_mem_write_data),    CLW'(h_data));
                check("w_hold_strb", CLW'(bus.o_write_strobe),      CLW'(h_strb));
            end
            if (rr_now) begin
                check("r_outstanding", CLW'(outst), CLW'(0));
                check("r_busy",        CLW'(m_busy), CLW'(1));
                check("raw_order",     CLW'(m_count), CLW'(0));
                check("r_addr",        CLW'(bus.o_mem_read_address), CLW'(m_raddr));
                r_if  = 1'b1;
                r_cnt = (rlat_fix != 0) ? rlat_fix : int'($urandom_range(3, 1));
                t_rr  = cyc_n;
            end
        end
        bus.i_mem_write_done = extra_wd;
        bus.i_mem_read_done  = extra_rd;
        bus.i_cache_line     = rand_line();
        if (w_if && !wv_now) begin
            w_cnt--;
            if (w_cnt == 0) bus.i_mem_write_done = 1'b1;
        end
        if (r_if && !rr_now) begin
            r_cnt--;
            if (r_cnt == 0) bus.i_mem_read_done = 1'b1;
        end
        if (rst) begin
            expwq.delete();
            m_count = 0; m_busy = 1'b0; w_if = 1'b0; r_if = 1'b0;
            exp_ready = 1'b1; exp_empty = 1'b1; exp_rdone = 1'b0;
            exp_line = '0; prev_empty = 1'b1; chk_en = 1'b1;
        end else begin
            push = (bus.i_wr_valid === 1'b1) && exp_ready;
            acc  = (bus.i_refill_req === 1'b1) && !m_busy;
            wpop = (bus.i_mem_write_done === 1'b1) && w_if;
            rret = (bus.i_mem_read_done === 1'b1) && r_if;
            if (push) begin
                f.a = bus.i_wr_addr; f.d = bus.i_wr_data; f.be = bus.i_wr_be;
                expwq.push_back(f);
                m_count++;
            end
            if (wpop) begin
                w_if = 1'b0;
                m_count--;
            end
            if (acc) begin
                m_busy  = 1'b1;
                m_raddr = bus.i_refill_addr;
            end
            exp_rdone = rret;
            if (rret) begin
                r_if     = 1'b0;
                m_busy   = 1'b0;
                exp_line = bus.i_cache_line;
            end
            exp_ready = (m_count < WBD) && !m_busy;
            exp_empty = (m_count == 0);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    initial begin
        int t0, nw0, nr0, k;
        rst = 1'b1;
        bus.i_refill_req = 1'b0; bus.i_refill_addr = '0;
        bus.i_wr_valid = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_wr_be = 4'h0;
        bus.i_mem_read_done = 1'b0; bus.i_mem_write_done = 1'b0; bus.i_cache_line = '0;
        chk_en = 1'b0; extra_wd = 1'b0; extra_rd = 1'b0; wlat_fix = 0; rlat_fix = 0;
        m_count = 0; m_busy = 1'b0; w_if = 1'b0; r_if = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cyc();
        rst = 1'b0;
        check_reset_outputs();

        // Refill only, memory answers one cycle after read_req.
        wlat_fix = 1; rlat_fix = 1;
        t0 = cyc_n; nw0 = n_wv;
        bus.i_refill_req = 1'b1; bus.i_refill_addr = 32'h0000_0040;
        cyc();
        bus.i_refill_req = 1'b0;
        repeat (5) cyc();
        check("t1_read_req_cycle", CLW'(t_rr),    CLW'(t0 + 1));
        check("t1_done_cycle",     CLW'(t_rdone), CLW'(t0 + 3));
        check("t1_no_write",       CLW'(n_wv),    CLW'(nw0));

        // Single store latency and strobe mapping.
        t0 = cyc_n; nw0 = n_wv;
        set_store(32'h0000_1000, 32'hDEAD_BEEF, 4'b0101);
        cyc();
        bus.i_wr_valid = 1'b0;
        repeat (6) cyc();
        check("t2_write_cycle", CLW'(t_wv),      CLW'(t0 + 2));
        check("t2_strobe",      CLW'(last_strb), CLW'(8'h05));
        check("t2_one_write",   CLW'(n_wv),      CLW'(nw0 + 1));
        check("t2_empty_cycle", CLW'(t_er),      CLW'(t0 + 4));

        // Fill the buffer with slow memory, then wrap the pointers.
        wlat_fix = 3; nw0 = n_wv;
        for (int i = 0; i < 4; i++) begin
            set_store($urandom(), $urandom(), 4'($urandom()));
            cyc();
        end
        bus.i_wr_valid = 1'b0;
        check("t3_full_ready", CLW'(bus.o_wr_ready), CLW'(0));
        repeat (20) cyc();
        wlat_fix = 0;
        for (int i = 0; i < 3; i++) begin
            set_store($urandom(), $urandom(), 4'($urandom()));
            cyc();
        end
        bus.i_wr_valid = 1'b0;
        repeat (30) cyc();
        check("t3_write_count", CLW'(n_wv), CLW'(nw0 + 7));

        // Stores buffered ahead of a refill must all drain first.
        rlat_fix = 0; nr0 = n_rdone;
        set_store(32'h0000_2000, $urandom(), 4'hF); cyc();
        set_store(32'h0000_2004, $urandom(), 4'h3); cyc();
        bus.i_refill_req = 1'b1; bus.i_refill_addr = 32'h0000_2000;
        set_store(32'h0000_2008, $urandom(), 4'hC); cyc();
        bus.i_refill_req = 1'b0;
        repeat (2) begin
            set_store($urandom(), $urandom(), 4'hF);
            cyc();
        end
        bus.i_wr_valid = 1'b0;
        k = 0;
        while (n_rdone == nr0 && k < 60) begin
            cyc();
            k++;
        end
        check("t4_refill_done", CLW'(n_rdone), CLW'(nr0 + 1));
        check("t4_read_after_write", CLW'(t_rr > t_wv), CLW'(1));

        // Reset in RD_WAIT, followed by a late read done.
        rlat_fix = 3;
        bus.i_refill_req = 1'b1; bus.i_refill_addr = 32'h0000_3000;
        cyc();
        bus.i_refill_req = 1'b0;
        k = 0;
        while (!r_if && k < 10) begin
            cyc();
            k++;
        end
        check("t5_read_issued", CLW'(r_if), CLW'(1));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_reset_outputs();
        nr0 = n_rdone;
        extra_rd = 1'b1;
        cyc();
        extra_rd = 1'b0;
        repeat (4) cyc();
        check("t5_no_done", CLW'(n_rdone), CLW'(nr0));
        check("t5_empty",   CLW'(bus.o_wb_empty), CLW'(1));

        // Stray dones while idle.
        nr0 = n_rdone; nw0 = n_wv;
        extra_wd = 1'b1; extra_rd = 1'b1;
        cyc();
        extra_wd = 1'b0; extra_rd = 1'b0;
        repeat (3) cyc();
        check("t6_no_done",  CLW'(n_rdone), CLW'(nr0));
        check("t6_no_write", CLW'(n_wv),    CLW'(nw0));
        check("t6_ready",    CLW'(bus.o_wr_ready), CLW'(1));

        // Random traffic with random memory latency.
        wlat_fix = 0; rlat_fix = 0;
        for (int i = 0; i < 800; i++) begin
            bus.i_wr_valid   = ($urandom() % 100) < 40;
            bus.i_wr_addr    = $urandom();
            bus.i_wr_data    = $urandom();
            bus.i_wr_be      = 4'($urandom());
            bus.i_refill_req = ($urandom() % 100) < 6;
            bus.i_refill_addr = $urandom();
            cyc();
        end
        bus.i_wr_valid = 1'b0; bus.i_refill_req = 1'b0;
        k = 0;
        while (k < 300 && (m_count != 0 || m_busy || w_if || r_if)) begin
            cyc();
            k++;
        end
        check("drain_complete", CLW'(k < 300), CLW'(1));
        check("drain_empty", CLW'(bus.o_wb_empty), CLW'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
